// File: rtl/data_mem_arbiter.sv
// Two-port (core / eFPGA fabric) arbiter onto a single-port SRAM with fixed
// one-cycle response latency, round-robin or core-priority with a starvation guard.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned MAX_WAIT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prio_mode_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [3:0]        core_be_i,
    input  logic [31:0]       core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic              core_err_o,
    output logic [31:0]       core_rdata_o,
    input  logic              fab_req_i,
    input  logic              fab_we_i,
    input  logic [3:0]        fab_be_i,
    input  logic [31:0]       fab_addr_i,
    input  logic [31:0]       fab_wdata_i,
    output logic              fab_gnt_o,
    output logic              fab_rvalid_o,
    output logic              fab_err_o,
    output logic [31:0]       fab_rdata_o,
    output logic              sram_csb0_o,
    output logic              sram_web0_o,
    output logic [3:0]        sram_wmask0_o,
    output logic [ADDR_W-1:0] sram_addr0_o,
    output logic [31:0]       sram_din0_o,
    input  logic [31:0]       sram_dout0_i
);

    localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {KIND_RD, KIND_WR, KIND_ERR} kind_t;

    logic           last_owner;
    logic           resp_valid;
    logic           resp_owner;
    kind_t          resp_kind;
    logic [WCW-1:0] wait_cnt;

    logic        fab_wins, gnt_core, gnt_fab, any_gnt;
    logic        sel_we, sel_oor;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr, sel_wdata;

    // Byte-offset bits never reach the word-addressed SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr_i[1:0], fab_addr_i[1:0]};

    always_comb begin
        if (prio_mode_i) fab_wins = (wait_cnt == WAIT_SAT);
        else             fab_wins = ~last_owner;
        gnt_fab  = ~rst & fab_req_i & (~core_req_i | fab_wins);
        gnt_core = ~rst & core_req_i & ~gnt_fab;
        any_gnt  = gnt_core | gnt_fab;
    end

    always_comb begin
        sel_we    = gnt_fab ? fab_we_i    : core_we_i;
        sel_be    = gnt_fab ? fab_be_i    : core_be_i;
        sel_addr  = gnt_fab ? fab_addr_i  : core_addr_i;
        sel_wdata = gnt_fab ? fab_wdata_i : core_wdata_i;
        sel_oor   = (sel_addr >> (ADDR_W + 2)) != 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= 1'b1;
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
            resp_kind  <= KIND_RD;
            wait_cnt   <= '0;
        end else begin
            if (any_gnt) last_owner <= gnt_fab;
            resp_valid <= any_gnt;
            resp_owner <= gnt_fab;
            if (sel_oor)     resp_kind <= KIND_ERR;
            else if (sel_we) resp_kind <= KIND_WR;
            else             resp_kind <= KIND_RD;
            if (!fab_req_i || gnt_fab)  wait_cnt <= '0;
            else if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        sram_csb0_o   = 1'b1;
        sram_web0_o   = 1'b1;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
        if (any_gnt && !sel_oor) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = ~sel_we;
            sram_wmask0_o = sel_be;
            sram_addr0_o  = sel_addr[ADDR_W+1:2];
            sram_din0_o   = sel_wdata;
        end
    end

    logic [31:0] resp_data;
    logic        resp_err;

    always_comb begin
        resp_data     = (resp_kind == KIND_RD) ? sram_dout0_i : '0;
        resp_err      = (resp_kind == KIND_ERR);
        core_gnt_o    = gnt_core;
        fab_gnt_o     = gnt_fab;
        core_rvalid_o = resp_valid & ~resp_owner;
        fab_rvalid_o  = resp_valid &  resp_owner;
        core_rdata_o  = core_rvalid_o ? resp_data : '0;
        fab_rdata_o   = fab_rvalid_o  ? resp_data : '0;
        core_err_o    = core_rvalid_o & resp_err;
        fab_err_o     = fab_rvalid_o  & resp_err;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the SRAM word-address width (256 words).
REQ-002 SHALL have parameter MAX_WAIT, default 7, the maximum number of cycles the fabric requester waits in fixed-priority mode before it is forced a grant.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports listed below; clock and reset come first.
REQ-004 clk  in  1  single clock for all state and for the SRAM port.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 prio_mode_i  in  1  arbitration mode: 0 = round-robin, 1 = core priority with starvation guard.
REQ-007 core_req_i, core_we_i  in  1 each  core request and write enable.
REQ-008 core_be_i  in  4  core byte enables.
REQ-009 core_addr_i, core_wdata_i  in  32 each  core byte address and write data.
REQ-010 core_gnt_o, core_rvalid_o, core_err_o  out  1 each  core grant, response valid and response error.
REQ-011 core_rdata_o  out  32  core read data.
REQ-012 fab_* SHALL be an identical port set for the eFPGA fabric requester (fab_req_i … fab_rdata_o).
REQ-013 sram_csb0_o, sram_web0_o  out  1 each  active-low chip select and active-low write enable.
REQ-014 sram_wmask0_o  out  4  SRAM write mask.
REQ-015 sram_addr0_o  out  ADDR_W  SRAM word address.
REQ-016 sram_din0_o  out  32  SRAM write data.
REQ-017 sram_dout0_i  in  32  SRAM read data.

Function
REQ-018 At most one gnt SHALL be asserted per cycle; gnt is combinational from the req inputs and the registered arbitration state.
REQ-019 Word address SHALL be addr[ADDR_W+1:2]; a request is out-of-range if any of addr[31:ADDR_W+2] is 1.
REQ-020 In-range grant cycle: csb0=0, web0=~we, wmask0=be, addr0/din0 taken from the granted port.
REQ-021 All other cycles, including out-of-range grants: csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
REQ-022 Every grant (read or write) SHALL produce exactly one rvalid pulse to the same requester in the next cycle (fixed latency 1).
REQ-023 Response to an in-range read: rdata = sram_dout0_i and err=0.
REQ-024 Response to an in-range write: rdata = 0 and err=0.
REQ-025 Response to an out-of-range access: rdata = 0 and err=1.
REQ-026 rdata and err of a port SHALL be 0 whenever that port's rvalid is 0.
REQ-027 Registered state: last_owner (0=core, 1=fabric), resp_valid, resp_owner, resp_kind (read/write/err), wait_cnt (width ceil(log2(MAX_WAIT+1))).
REQ-028 Round-robin mode, single requester: that requester is granted.
REQ-029 Round-robin mode, both requesting: the requester that is not last_owner is granted.
REQ-030 Fixed mode: core wins a contention unless wait_cnt == MAX_WAIT, in which case the fabric wins.
REQ-031 wait_cnt SHALL increment (saturating at MAX_WAIT) each cycle fab_req_i=1 and fabric is not granted.
REQ-032 wait_cnt SHALL clear on a fabric grant or whenever fab_req_i=0.
REQ-033 last_owner SHALL update on every grant; it is held when no grant occurs.
REQ-034 A requester may drop req without penalty before it is granted; a dropped request is not stored.
REQ-035 Back-to-back grants SHALL be supported: a new grant and the previous response's rvalid may coincide in the same cycle.
REQ-036 prio_mode_i changes SHALL take effect in the same cycle; wait_cnt is retained across mode changes.

Reset
REQ-037 While rst=1: all gnt, rvalid and err outputs are 0, rdata=0, csb0=1, web0=1, other SRAM outputs are 0.
REQ-038 On reset, last_owner resets to 1 (core wins the first contention), and resp_valid and wait_cnt reset to 0.
REQ-039 A reset asserted between grant and response SHALL discard the pending response; no rvalid appears after reset release.

Verification
REQ-040 Core read 0x0000_0010 with SRAM word 4 = 0xDEADBEEF: core_gnt in cycle N with addr0=4 and csb0=0; core_rvalid in N+1 with rdata=0xDEADBEEF and err=0.
REQ-041 Round-robin, both requesters held high for 4 cycles from reset: grant order is core, fab, core, fab; rvalid follows each grant by one cycle to the matching port.
REQ-042 Fixed mode, core and fabric held high with MAX_WAIT=7: core granted in cycles 0–6, fab granted in cycle 7, wait_cnt back to 0 in cycle 8.
REQ-043 Fabric write to 0x0000_0400 (out-of-range): fab_gnt=1 with csb0=1; next cycle fab_rvalid=1, fab_err=1, fab_rdata=0; SRAM content unchanged.
REQ-044 Core write be=4'b0011 wdata=0x12345678 to word 2: wmask0=0011 and web0=0; rvalid next cycle with rdata=0; a read-back of word 2 returns 0x????5678, with the upper half unchanged.
REQ-045 Reset asserted in the cycle after a fab grant: no fab_rvalid appears; after release, the first contention goes to core.
